// File: rtl/adam_apb_axil_bridge.sv
// adam_apb_axil_bridge: APB completer to AXI-Lite manager bridge.
// Takes one APB transfer at a time and re-issues it as a single AXI-Lite
// read or write. Only one AXI transaction is ever outstanding.
// Optional feature macro: ADAM_APB_AXIL_BRIDGE_ALIGN_CHECK_EN. When defined,
// misaligned addresses complete locally with pslverr and never reach AXI.
module adam_apb_axil_bridge #(
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PAUSED, ST_WR_REQ, ST_WR_RSP, ST_RD_REQ, ST_RD_RSP, ST_DONE
  } state_e;

  state_e                  state_r, state_s;
  logic                    capture_s;
  logic                    misalign_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [2:0]              prot_r;
  logic                    write_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [STRB_WIDTH-1:0]   strb_r;
  logic                    awvalid_r, awvalid_s;
  logic                    wvalid_r, wvalid_s;
  logic                    arvalid_r, arvalid_s;
  logic                    bready_r, bready_s;
  logic                    rready_r, rready_s;
  logic                    pready_r, pready_s;
  logic                    pslverr_r, pslverr_s;
  logic [DATA_WIDTH-1:0]   prdata_r, prdata_s;
  logic                    pause_ack_r, pause_ack_s;
  logic                    unused_s;

`ifdef ADAM_APB_AXIL_BRIDGE_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  assign misalign_s = |(paddr & ALIGN_MASK);
`else
  assign misalign_s = 1'b0;
`endif

  // penable plays no part in the start decision; resp bit 0 carries no error meaning
  assign unused_s = ^{penable, bresp[0], rresp[0], write_r};

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output decisions for the transfer sequencer
  always_comb begin
    state_s     = state_r;
    capture_s   = 1'b0;
    awvalid_s   = awvalid_r;
    wvalid_s    = wvalid_r;
    arvalid_s   = arvalid_r;
    bready_s    = bready_r;
    rready_s    = rready_r;
    pready_s    = 1'b0;
    pslverr_s   = pslverr_r;
    prdata_s    = prdata_r;
    pause_ack_s = pause_ack_r;
    case (state_r)
      ST_IDLE: begin
        if (pause_req) begin
          state_s     = ST_PAUSED;
          pause_ack_s = 1'b1;
        end else if (psel) begin
          capture_s = 1'b1;
          if (misalign_s) begin
            state_s   = ST_DONE;
            pready_s  = 1'b1;
            pslverr_s = 1'b1;
          end else if (pwrite) begin
            state_s   = ST_WR_REQ;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
          end else begin
            state_s   = ST_RD_REQ;
            arvalid_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PAUSED: begin
        if (!pause_req) begin
          state_s     = ST_IDLE;
          pause_ack_s = 1'b0;
        end else begin
          state_s = ST_PAUSED;
        end
      end
      ST_WR_REQ: begin
        // address and data channels retire independently
        awvalid_s = awvalid_r & ~awready;
        wvalid_s  = wvalid_r & ~wready;
        if (!awvalid_s && !wvalid_s) begin
          state_s  = ST_WR_RSP;
          bready_s = 1'b1;
        end else begin
          state_s = ST_WR_REQ;
        end
      end
      ST_WR_RSP: begin
        if (bvalid) begin
          state_s   = ST_DONE;
          bready_s  = 1'b0;
          pready_s  = 1'b1;
          pslverr_s = bresp[1];
        end else begin
          state_s = ST_WR_RSP;
        end
      end
      ST_RD_REQ: begin
        if (arready) begin
          state_s   = ST_RD_RSP;
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
        end else begin
          state_s = ST_RD_REQ;
        end
      end
      ST_RD_RSP: begin
        if (rvalid) begin
          state_s   = ST_DONE;
          rready_s  = 1'b0;
          pready_s  = 1'b1;
          pslverr_s = rresp[1];
          prdata_s  = rdata;
        end else begin
          state_s = ST_RD_RSP;
        end
      end
      ST_DONE: begin
        state_s   = ST_IDLE;
        pslverr_s = 1'b0;
      end
      default: begin
        state_s   = ST_IDLE;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        arvalid_s = 1'b0;
        bready_s  = 1'b0;
        rready_s  = 1'b0;
        pslverr_s = 1'b0;
      end
    endcase
  end

  // Capture the APB request when a transfer starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r  <= '0;
      prot_r  <= 3'd0;
      write_r <= 1'b0;
      wdata_r <= '0;
      strb_r  <= '0;
    end else if (capture_s) begin
      addr_r  <= paddr;
      prot_r  <= pprot;
      write_r <= pwrite;
      wdata_r <= pwdata;
      strb_r  <= pstrb;
    end
  end

  // Registered handshake and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
      rready_r    <= 1'b0;
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
      prdata_r    <= '0;
      pause_ack_r <= 1'b0;
    end else begin
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      arvalid_r   <= arvalid_s;
      bready_r    <= bready_s;
      rready_r    <= rready_s;
      pready_r    <= pready_s;
      pslverr_r   <= pslverr_s;
      prdata_r    <= prdata_s;
      pause_ack_r <= pause_ack_s;
    end
  end

  assign pause_ack = pause_ack_r;
  assign prdata    = prdata_r;
  assign pready    = pready_r;
  assign pslverr   = pslverr_r;
  assign awaddr    = addr_r;
  assign awprot    = prot_r;
  assign awvalid   = awvalid_r;
  assign wdata     = wdata_r;
  assign wstrb     = strb_r;
  assign wvalid    = wvalid_r;
  assign bready    = bready_r;
  assign araddr    = addr_r;
  assign arprot    = prot_r;
  assign arvalid   = arvalid_r;
  assign rready    = rready_r;

endmodule

// File: tb/tb_adam_apb_axil_bridge.sv
// Testbench for adam_apb_axil_bridge: directed and randomized APB transfers
// against a small AXI-Lite memory slave, checked against a word-addressed
// reference memory and latency rules derived from the handshake delays.
module tb_adam_apb_axil_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause_req = 1'b0;
  logic        pause_ack;
  logic [31:0] paddr = 32'h0;
  logic [2:0]  pprot = 3'd0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  int errors = 0;
  int checks = 0;

  // reference memory (fed from the APB side) and slave memory (fed from AXI side)
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] slv_mem [logic [29:0]];
  logic [31:0] last_rd = 32'h0;

  // per-transfer observations
  int          res_cycles, res_viol, res_hs_edge, res_rdy_edge;
  logic [31:0] res_prdata, res_addr, res_wdata;
  logic [3:0]  res_strb;
  logic [2:0]  res_prot;
  logic        res_pslverr, res_axi_seen, res_valid_at_done, res_aborted;

  adam_apb_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    else return 32'h0;
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    if (slv_mem.exists(a[31:2])) return slv_mem[a[31:2]];
    else return 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a[31:2]] = d;
    slv_mem[a[31:2]] = d;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 32'({awvalid, wvalid, arvalid, bready, rready, pready, pslverr, pause_ack}), 32'h0);
    check({tag, "_prdata"}, prdata, 32'h0);
    check({tag, "_addr"}, awaddr | araddr, 32'h0);
    check({tag, "_wdata"}, wdata | 32'(wstrb), 32'h0);
  endtask

  // One APB transfer; the same loop also plays the AXI-Lite slave.
  // da/dw: wait cycles before aw(ar)/w ready, dr: wait before b/r valid.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      input int da, input int dw, input int dr,
                      input logic [1:0] rs, input bit abort);
    int edges, a_cnt, w_cnt, r_cnt;
    bit a_done, w_done, rsp_fire, fin;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    edges = 0; a_cnt = 0; w_cnt = 0; r_cnt = 0;
    a_done = 1'b0; w_done = 1'b0; rsp_fire = 1'b0; fin = 1'b0;
    res_viol = 0; res_hs_edge = -1; res_rdy_edge = -1; res_aborted = 1'b0;
    res_valid_at_done = 1'b0; res_addr = 32'h0; res_wdata = 32'h0; res_strb = 4'h0; res_prot = 3'd0;
    while (!fin && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      penable = 1'b1;
      if (pready) begin
        fin = 1'b1;
        res_rdy_edge = edges;
        res_prdata = prdata;
        res_pslverr = pslverr;
        res_valid_at_done = awvalid | wvalid | arvalid;
      end else if (abort && rready) begin
        rst = 1'b0;
        #1;
        check_reset("rst_mid");
        res_aborted = 1'b1;
        fin = 1'b1;
      end else if (wr) begin
        if (arvalid) res_viol++;
        if (bvalid) begin
          if (bready && !rsp_fire) begin rsp_fire = 1'b1; res_hs_edge = edges + 1; end
        end else if (a_done && w_done) begin
          if (r_cnt >= dr) begin
            bvalid = 1'b1; bresp = rs;
            if (!rs[1]) slv_mem[res_addr[31:2]] = merge(slv_read(res_addr), res_wdata, res_strb);
            if (bready) begin rsp_fire = 1'b1; res_hs_edge = edges + 1; end
          end else r_cnt++;
        end
        if (a_done) begin awready = 1'b0; if (awvalid) res_viol++; end
        else if (!awvalid) res_viol++;
        else if (a_cnt >= da) begin awready = 1'b1; a_done = 1'b1; res_addr = awaddr; res_prot = awprot; end
        else a_cnt++;
        if (w_done) begin wready = 1'b0; if (wvalid) res_viol++; end
        else if (!wvalid) res_viol++;
        else if (w_cnt >= dw) begin wready = 1'b1; w_done = 1'b1; res_wdata = wdata; res_strb = wstrb; end
        else w_cnt++;
      end else begin
        if (awvalid || wvalid) res_viol++;
        if (rvalid) begin
          if (rready && !rsp_fire) begin rsp_fire = 1'b1; res_hs_edge = edges + 1; end
        end else if (a_done) begin
          if (r_cnt >= dr) begin
            rvalid = 1'b1; rresp = rs; rdata = slv_read(res_addr);
            if (rready) begin rsp_fire = 1'b1; res_hs_edge = edges + 1; end
          end else r_cnt++;
        end
        if (a_done) begin arready = 1'b0; if (arvalid) res_viol++; end
        else if (!arvalid) res_viol++;
        else if (a_cnt >= da) begin arready = 1'b1; a_done = 1'b1; res_addr = araddr; res_prot = arprot; end
        else a_cnt++;
      end
    end
    check("xfer_finished", 32'(fin), 32'd1);
    res_axi_seen = a_done | w_done;
    res_cycles = res_rdy_edge + 1;
    if (fin && !res_aborted) begin
      @(posedge clk);
      #1;
      check("pready_one_cycle", 32'(pready), 32'd0);
    end
    psel = 1'b0; penable = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00;
  endtask

  // Transfer plus expectations from the reference model
  task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] p,
                     input int da, input int dw, input int dr, input logic [1:0] rs);
    logic [31:0] exp_rd;
    int          mx;
    exp_rd = ref_read(a);
    mx = (da > dw) ? da : dw;
    xfer(wr, a, d, s, p, da, dw, dr, rs, 1'b0);
    check("no_valid_at_done", 32'(res_valid_at_done), 32'd0);
`ifdef ADAM_APB_AXIL_BRIDGE_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      check("misal_cycles", res_cycles, 32'd2);
      check("misal_pslverr", 32'(res_pslverr), 32'd1);
      check("misal_no_axi", 32'(res_axi_seen), 32'd0);
      check("misal_prdata", res_prdata, last_rd);
    end else
`endif
    if (wr) begin
      check("wr_cycles", res_cycles, 32'(mx + dr + 4));
      check("wr_pslverr", 32'(res_pslverr), 32'(rs[1]));
      check("wr_awaddr", res_addr, a);
      check("wr_awprot", 32'(res_prot), 32'(p));
      check("wr_wdata", res_wdata, d);
      check("wr_wstrb", 32'(res_strb), 32'(s));
      check("wr_prdata_held", res_prdata, last_rd);
      check("wr_protocol", res_viol, 32'd0);
      check("wr_rsp_to_pready", res_rdy_edge, res_hs_edge);
      if (!rs[1]) ref_mem[a[31:2]] = merge(exp_rd, d, s);
    end else begin
      check("rd_cycles", res_cycles, 32'(da + dr + 4));
      check("rd_pslverr", 32'(res_pslverr), 32'(rs[1]));
      check("rd_araddr", res_addr, a);
      check("rd_arprot", 32'(res_prot), 32'(p));
      check("rd_prdata", res_prdata, exp_rd);
      check("rd_protocol", res_viol, 32'd0);
      check("rd_rsp_to_pready", res_rdy_edge, res_hs_edge);
      last_rd = exp_rd;
    end
  endtask

  task automatic pause_test();
    @(negedge clk);
    pause_req = 1'b1;
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h108; pwdata = 32'h600D_CAFE; pstrb = 4'hF; pprot = 3'd0;
    @(posedge clk);
    #1;
    check("pause_ack_rise", 32'(pause_ack), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("pause_quiet", 32'({awvalid, wvalid, arvalid, pready}), 32'd0);
    end
    check("pause_ack_held", 32'(pause_ack), 32'd1);
    @(negedge clk);
    pause_req = 1'b0;
    @(posedge clk);
    #1;
    check("pause_ack_fall", 32'(pause_ack), 32'd0);
    run(1'b1, 32'h108, 32'h600D_CAFE, 4'hF, 3'd0, 0, 0, 0, 2'b00);
  endtask

  initial begin
    bit          w;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [2:0]  p;
    logic [1:0]  rs;
    int          da, dw, dr;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    run(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 0, 2'b00);
    preload(32'h200, 32'h1234_5678);
    run(1'b0, 32'h200, 32'h0, 4'h0, 3'd2, 0, 0, 5, 2'b00);
    run(1'b1, 32'h104, 32'hA5A5_5A5A, 4'hF, 3'd1, 3, 0, 0, 2'b10);
    run(1'b0, 32'h100, 32'h0, 4'h0, 3'd0, 0, 0, 0, 2'b00);
    pause_test();
    run(1'b1, 32'h102, 32'h1122_3344, 4'h3, 3'd0, 0, 0, 0, 2'b00);
    run(1'b0, 32'h104, 32'h0, 4'h0, 3'd5, 1, 0, 2, 2'b11);
    run(1'b0, 32'h108, 32'h0, 4'h0, 3'd0, 0, 0, 0, 2'b01);

    // reset while waiting in the read response phase, then a clean read of 0x0
    preload(32'h0, 32'h0BAD_F00D);
    xfer(1'b0, 32'h300, 32'h0, 4'h0, 3'd0, 0, 0, 40, 2'b00, 1'b1);
    check("rst_mid_reached", 32'(res_aborted), 32'd1);
    last_rd = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 2'b00);

    for (int i = 0; i < 24; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      d  = $urandom;
      s  = 4'($urandom_range(1, 15));
      p  = 3'($urandom_range(0, 7));
      da = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 3));
      dr = int'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      run(w, a, d, s, p, da, dw, dr, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
